qtr_reader: RTL
===============

Name: qtr_reader

Overview:
- Timing core for Pololu QTR reflectance sensors on the Romi board.
- Sits directly downstream of the top-level GPIO SB_IO tristate buffers. Drives their out_en/out_sig lines and consumes their in_sig lines, replacing software bit-banging through hba_gpio.
- Repeatedly runs this cycle: charge the sensor line, release it, then time the decay in microseconds.
- Publishes per-sensor readings with a valid strobe. A future hba_qtr register wrapper in hba_system reads these.

Parameters:
- CLK_FREQUENCY, 60_000_000, system clock in Hz; must be an integer multiple of 1_000_000.
- NUM_SENSORS, 2, number of QTR channels (left, right).
- COUNT_WIDTH, 12, width of each reading in microseconds.
- CHARGE_US, 10, charge time in microseconds.
- TIMEOUT_US, 2500, maximum measurable decay; must be below 2**COUNT_WIDTH.
- PERIOD_US, 5000, start-to-start spacing of measurement cycles; must exceed CHARGE_US+TIMEOUT_US+2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; when high, run measurement cycles back to back at PERIOD_US.
- qtr_out_en  out  NUM_SENSORS  to SB_IO OUTPUT_ENABLE.
- qtr_out_sig  out  NUM_SENSORS  to SB_IO D_OUT_0.
- qtr_in_sig  in  NUM_SENSORS  from SB_IO D_IN_0; asynchronous to clk.
- qtr_ctrl  out  NUM_SENSORS  emitter LED enable, one per sensor.
- qtr_value  out  NUM_SENSORS*COUNT_WIDTH  latest decay times; sensor i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- qtr_valid  out  1  one-cycle pulse when qtr_value updates.
- busy  out  1  high in all states except IDLE.

Behaviour:
- Reset (asynchronous): state IDLE.
  - All outputs 0: out_en, out_sig, ctrl, value, valid, busy.
  - Prescaler, us counter, period counter and latch flags cleared.
- Input sync: qtr_in_sig passes through a 2-FF synchronizer before use. Sync flops reset to 1.
- us_tick: 1-cycle pulse every CLK_FREQUENCY/1_000_000 clocks.
  - The prescaler restarts at 0 on entry to CHARGE and on entry to MEASURE, so every timed phase is cycle-exact.
- States:
  - IDLE
    - Outputs: out_en=0, ctrl=0.
    - Transition: if enable=1, go to CHARGE on the next cycle.
  - CHARGE
    - Outputs: out_en=all 1, out_sig=all 1, ctrl=all 1.
    - Period counter starts at 0 on entry.
    - Transition: after CHARGE_US ticks, go to MEASURE.
  - MEASURE
    - Outputs: out_en=0, ctrl=1.
    - us counter starts at 0 and increments on each tick.
    - Per sensor: the first cycle its synced input is 0 with latch flag clear, capture the us counter into its work register and set its flag.
    - Transition: go to DONE when all flags are set, or when the us counter reaches TIMEOUT_US. Unlatched sensors load TIMEOUT_US (saturate).
  - DONE (1 cycle)
    - Copy work registers to qtr_value, pulse qtr_valid=1, set ctrl=0.
    - Transition: go to WAIT.
  - WAIT
    - Transition: when the period counter, which has counted ticks since CHARGE entry, reaches PERIOD_US, go to CHARGE if enable=1, else IDLE.
- Period: start-to-start spacing = PERIOD_US us, cycle-exact.
- enable=0 in CHARGE, MEASURE or WAIT: abort to IDLE on the next cycle.
  - out_en=0 and ctrl=0 from that cycle.
  - qtr_value is held and no qtr_valid is issued.
  - Latch flags clear.
- A sensor already low at MEASURE entry reads 0. A sensor that never falls reads exactly TIMEOUT_US.
- Simultaneous latch with timeout on the same cycle: the captured count wins; it equals TIMEOUT_US anyway.
- qtr_value changes only in DONE.

Optional Feature:
- Macro: QTR_THRESH_EN.
- Defined:
  - Adds input thresh (COUNT_WIDTH) and output qtr_line (NUM_SENSORS).
  - qtr_line[i] is registered in DONE as (value_i >= thresh): dark line = long decay.
  - Resets to 0; held on abort.
- Undefined: neither port exists and no comparator logic is present.

Decomposition:
- Package qtr_pkg contains:
  - state enum: IDLE, CHARGE, MEASURE, DONE, WAIT.
  - derived constant US_DIV = CLK_FREQUENCY/1_000_000.
  - width helper for the period counter, $clog2(PERIOD_US+1).
- Sub-module qtr_us_tick: prescaler with synchronous restart input and tick output.

Test Plan (bench overrides: CLK_FREQUENCY=4_000_000, CHARGE_US=10, TIMEOUT_US=100, PERIOD_US=200):
- Reset asserted mid-MEASURE:
  - All outputs 0 within the same cycle.
  - After release with enable=1, CHARGE begins on the next cycle.
- Sensor models: sensor0 falls 37 us after MEASURE entry, sensor1 falls at 62 us.
  - qtr_valid pulses once; value0=37, value1=62.
  - CHARGE lasts exactly 40 clocks.
  - Next CHARGE starts 800 clocks after the previous one.
- Sensor1 never falls:
  - value1=100, DONE occurs 400 clocks after MEASURE entry, value0 correct.
- Both inputs held low throughout:
  - values 0,0; DONE follows MEASURE within 4 clocks.
- enable dropped at MEASURE +20 us:
  - IDLE next cycle, no qtr_valid, previous qtr_value held, out_en=0, ctrl=0.
- QTR_THRESH_EN, thresh=50, readings 37/62:
  - qtr_line=2'b10, updated in the same cycle as qtr_valid.

Source files
------------

// File: rtl/qtr_reader_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qtr_pkg
// Shared types and constants for the QTR reflectance sensor timing core.
//   state_t      - measurement FSM states
//   US_DIV       - clocks per microsecond at the default 60 MHz system clock
//   calcUsDiv    - clocks per microsecond for an arbitrary clock frequency
//   periodWidth  - bit width needed to count 0..PERIOD_US inclusive
// -----------------------------------------------------------------------------
package qtr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        MEASURE,
        DONE,
        WAIT
    } state_t;

    localparam int DEFAULT_CLK_FREQUENCY = 60_000_000;
    localparam int US_DIV                = DEFAULT_CLK_FREQUENCY / 1_000_000;

    function automatic int calcUsDiv(input int clkFrequency);
        return clkFrequency / 1_000_000;
    endfunction

    function automatic int periodWidth(input int periodUs);
        return $clog2(periodUs + 1);
    endfunction

endpackage

// File: rtl/qtr_reader_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qtr_reader_if
// Bundles the sensor-facing GPIO lines and the reading/status outputs of the
// QTR timing core.
//   enable       - level, run measurement cycles while high
//   qtr_out_en   - SB_IO OUTPUT_ENABLE, one per sensor
//   qtr_out_sig  - SB_IO D_OUT_0, one per sensor
//   qtr_in_sig   - SB_IO D_IN_0, asynchronous to the system clock
//   qtr_ctrl     - emitter LED enable, one per sensor
//   qtr_value    - latest decay times, sensor i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   qtr_valid    - one-cycle pulse when qtr_value updates
//   busy         - high whenever the core is not idle
// With QTR_THRESH_EN defined the bundle also carries:
//   thresh       - dark-line decay threshold in microseconds
//   qtr_line     - per-sensor line detect, registered with qtr_value
// master: the timing core.  slave: the system / sensor side.
// -----------------------------------------------------------------------------
interface qtr_reader_if #(
    parameter int NUM_SENSORS = 2,
    parameter int COUNT_WIDTH = 12
);

    logic                               enable;
    logic [NUM_SENSORS-1:0]             qtr_out_en;
    logic [NUM_SENSORS-1:0]             qtr_out_sig;
    logic [NUM_SENSORS-1:0]             qtr_in_sig;
    logic [NUM_SENSORS-1:0]             qtr_ctrl;
    logic [NUM_SENSORS*COUNT_WIDTH-1:0] qtr_value;
    logic                               qtr_valid;
    logic                               busy;
`ifdef QTR_THRESH_EN
    logic [COUNT_WIDTH-1:0]             thresh;
    logic [NUM_SENSORS-1:0]             qtr_line;

    modport master (
        input  enable, qtr_in_sig, thresh,
        output qtr_out_en, qtr_out_sig, qtr_ctrl, qtr_value, qtr_valid, busy, qtr_line
    );

    modport slave (
        output enable, qtr_in_sig, thresh,
        input  qtr_out_en, qtr_out_sig, qtr_ctrl, qtr_value, qtr_valid, busy, qtr_line
    );
`else
    modport master (
        input  enable, qtr_in_sig,
        output qtr_out_en, qtr_out_sig, qtr_ctrl, qtr_value, qtr_valid, busy
    );

    modport slave (
        output enable, qtr_in_sig,
        input  qtr_out_en, qtr_out_sig, qtr_ctrl, qtr_value, qtr_valid, busy
    );
`endif

endinterface

// File: rtl/qtr_reader_us_tick.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qtr_us_tick
// Microsecond prescaler: o_tick pulses for one clock every DIV clocks.
//   clk        - system clock
//   reset      - asynchronous, active-high
//   i_restart  - synchronous restart; the count is 0 in the following cycle
//   o_tick     - one-cycle pulse on the last clock of each DIV-clock window
// -----------------------------------------------------------------------------
module qtr_us_tick
    import qtr_pkg::*;
#(
    parameter int DIV = US_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;

    // Free-running modulo-DIV counter, forced back to zero on restart so the
    // first tick of a timed phase lands exactly DIV clocks after its entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart || (r_count == CW'(DIV - 1))) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // The tick is not masked by restart: phase changes happen on tick cycles,
    // and that tick must still be counted by the phase being left.
    assign o_tick = (r_count == CW'(DIV - 1));

endmodule

// File: rtl/qtr_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qtr_reader
// Timing core for Pololu QTR reflectance sensors. Each cycle charges the
// sensor lines, releases them and times the decay of each line in
// microseconds, then publishes the readings with a one-cycle valid strobe.
// Cycles repeat start-to-start every PERIOD_US while enable is high.
//   clk     - system clock (CLK_FREQUENCY Hz, integer multiple of 1 MHz)
//   reset   - asynchronous, active-high
//   io_qtr  - qtr_reader_if master: GPIO drive/sense, emitter control,
//             readings, valid strobe and busy
// Optional feature macro: QTR_THRESH_EN adds the thresh input and the
// registered qtr_line output (reading >= thresh means dark line).
// -----------------------------------------------------------------------------
module qtr_reader
    import qtr_pkg::*;
#(
    parameter int CLK_FREQUENCY = 60_000_000,
    parameter int NUM_SENSORS   = 2,
    parameter int COUNT_WIDTH   = 12,
    parameter int CHARGE_US     = 10,
    parameter int TIMEOUT_US    = 2500,
    parameter int PERIOD_US     = 5000
) (
    input  logic         clk,
    input  logic         reset,
    qtr_reader_if.master io_qtr
);

    localparam int DIV = calcUsDiv(CLK_FREQUENCY);
    localparam int PW  = periodWidth(PERIOD_US);

    state_t                                   r_state;
    state_t                                   w_nextState;
    logic [NUM_SENSORS-1:0]                   r_sync1;
    logic [NUM_SENSORS-1:0]                   r_sync2;
    logic [PW-1:0]                            r_periodCount;
    logic [COUNT_WIDTH-1:0]                   r_usCount;
    logic [NUM_SENSORS-1:0]                   r_flags;
    logic [NUM_SENSORS-1:0][COUNT_WIDTH-1:0]  r_work;
    logic [NUM_SENSORS-1:0][COUNT_WIDTH-1:0]  r_value;
    logic [NUM_SENSORS-1:0][COUNT_WIDTH-1:0]  w_workNext;
    logic [NUM_SENSORS-1:0]                   w_latchNow;
    logic                                     w_tick;
    logic                                     w_restart;
    logic                                     w_enterCharge;
    logic                                     w_enterMeasure;
    logic                                     w_timeout;
    logic                                     w_allLatched;
    logic                                     w_finish;
    logic [NUM_SENSORS-1:0]                   w_outEn;
    logic [NUM_SENSORS-1:0]                   w_outSig;
    logic [NUM_SENSORS-1:0]                   w_ctrl;
    logic                                     w_valid;
    logic                                     w_busy;

    assign w_enterCharge  = (w_nextState == CHARGE)  && (r_state != CHARGE);
    assign w_enterMeasure = (w_nextState == MEASURE) && (r_state != MEASURE);
    assign w_restart      = w_enterCharge || w_enterMeasure;
    assign w_timeout      = (r_state == MEASURE) && w_tick &&
                            (r_usCount == COUNT_WIDTH'(TIMEOUT_US - 1));
    assign w_allLatched   = &r_flags;
    assign w_finish       = (r_state == MEASURE) && (w_nextState == DONE);

    qtr_us_tick #(
        .DIV (DIV)
    ) u_usTick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Two-flop synchronizer for the asynchronous sensor lines. Idle-high so a
    // freshly reset core does not see a spurious discharged line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= io_qtr.qtr_in_sig;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic. The period counter doubles as the charge timer
    // because both start from zero on CHARGE entry. Dropping enable aborts
    // from any timed phase; DONE always completes so a reading is never torn.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (io_qtr.enable) w_nextState = CHARGE;
            end
            CHARGE: begin
                if (!io_qtr.enable) begin
                    w_nextState = IDLE;
                end else if (w_tick && (r_periodCount == PW'(CHARGE_US - 1))) begin
                    w_nextState = MEASURE;
                end
            end
            MEASURE: begin
                if (!io_qtr.enable) begin
                    w_nextState = IDLE;
                end else if (w_allLatched || w_timeout) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = WAIT;
            end
            WAIT: begin
                if (!io_qtr.enable) begin
                    w_nextState = IDLE;
                end else if (w_tick && (r_periodCount == PW'(PERIOD_US - 1))) begin
                    w_nextState = CHARGE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the registered state only.
    always_comb begin
        w_outEn  = '0;
        w_outSig = '0;
        w_ctrl   = '0;
        w_valid  = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
            end
            CHARGE: begin
                w_outEn  = '1;
                w_outSig = '1;
                w_ctrl   = '1;
            end
            MEASURE: begin
                w_ctrl = '1;
            end
            DONE: begin
                w_valid = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // Ticks elapsed since the current cycle entered CHARGE; sets the
    // start-to-start spacing of measurement cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_periodCount <= '0;
        end else if (w_enterCharge) begin
            r_periodCount <= '0;
        end else if ((r_state != IDLE) && w_tick) begin
            r_periodCount <= r_periodCount + PW'(1);
        end
    end

    // Microseconds elapsed since the lines were released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_usCount <= '0;
        end else if (w_enterMeasure) begin
            r_usCount <= '0;
        end else if ((r_state == MEASURE) && w_tick) begin
            r_usCount <= r_usCount + COUNT_WIDTH'(1);
        end
    end

    // Per-sensor capture: the first low sample takes the current count; a
    // sensor still high at timeout saturates to TIMEOUT_US. A capture on the
    // timeout cycle takes priority over the saturation value.
    always_comb begin
        w_workNext = r_work;
        w_latchNow = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_latchNow[i] = (r_state == MEASURE) && !r_sync2[i] && !r_flags[i];
            if (w_latchNow[i]) begin
                w_workNext[i] = r_usCount;
            end else if (w_timeout && !r_flags[i]) begin
                w_workNext[i] = COUNT_WIDTH'(TIMEOUT_US);
            end
        end
    end

    // Work registers and latch flags. Flags only live inside MEASURE, so an
    // abort or a completed cycle leaves them clear for the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work  <= '0;
            r_flags <= '0;
        end else begin
            r_work <= w_workNext;
            if (r_state == MEASURE) begin
                r_flags <= r_flags | w_latchNow;
            end else begin
                r_flags <= '0;
            end
        end
    end

    // Published readings load on the edge into DONE so they are already
    // visible while qtr_valid is high; aborts never reach this load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (w_finish) begin
            r_value <= w_workNext;
        end
    end

`ifdef QTR_THRESH_EN
    logic [NUM_SENSORS-1:0] r_line;

    // Line detect registered alongside the readings: a long decay means a
    // dark surface under the sensor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line <= '0;
        end else if (w_finish) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_line[i] <= (w_workNext[i] >= io_qtr.thresh);
            end
        end
    end

    assign io_qtr.qtr_line = r_line;
`endif

    assign io_qtr.qtr_out_en  = w_outEn;
    assign io_qtr.qtr_out_sig = w_outSig;
    assign io_qtr.qtr_ctrl    = w_ctrl;
    assign io_qtr.qtr_value   = r_value;
    assign io_qtr.qtr_valid   = w_valid;
    assign io_qtr.busy        = w_busy;

endmodule
